cpu_clk_ctrl: RTL and testbench
===============================

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Param FAST_LOG2, default 1: RUN-mode tick period is 2^FAST_LOG2 clk cycles when mode_slow=0.
REQ-002 Param SLOW_LOG2, default 25: RUN-mode tick period is 2^SLOW_LOG2 clk cycles when mode_slow=1; legal range FAST_LOG2..31.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run_sw  in  1  asynchronous run/halt switch level.
REQ-006 step_btn  in  1  asynchronous, pre-debounced single-step button level.
REQ-007 mode_slow  in  1  asynchronous slow/fast tick select.
REQ-008 pc  in  32  current CPU PC; used only with BRKPT_EN.
REQ-009 bp_addr  in  32  breakpoint address; used only with BRKPT_EN.
REQ-010 bp_valid  in  1  breakpoint armed; used only with BRKPT_EN.
REQ-011 cpu_en  out  1  registered one-cycle CPU clock-enable pulse.
REQ-012 halted  out  1  registered; high when state is HALT.
REQ-013 bp_hit  out  1  registered; high while halted by breakpoint.
REQ-014 step_cnt  out  32  count of cpu_en pulses issued.

Function
REQ-015 run_sw, step_btn, mode_slow SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized value against a third flop.
REQ-016 FSM states SHALL be HALT, RUN, STEP; state and cpu_en SHALL be registered, cpu_en=1 exactly when state=STEP or a RUN tick fires.
REQ-017 HALT: synced run_sw rising edge -> RUN; else synced step_btn rising edge -> STEP; run edge has priority on a simultaneous edge, and the step edge is discarded.
REQ-018 STEP SHALL last exactly one cycle with cpu_en=1, then return to HALT.
REQ-019 Latency: step_btn first sampled high at edge N -> cpu_en high after edge N+2, for one cycle.
REQ-020 RUN: 32-bit div_cnt cleared on entry, increments each cycle; tick when div_cnt[N-1:0] all ones, N selected by synced mode_slow; first cpu_en 2^N cycles after entering RUN, then every 2^N cycles.
REQ-021 mode_slow change in RUN SHALL NOT clear div_cnt; new N applies from the cycle the synced value changes.
REQ-022 RUN: synced run_sw low -> HALT on next edge; a tick coinciding with this SHALL be suppressed.
REQ-023 step_btn edges in RUN SHALL be ignored; level-high run_sw in HALT without an edge SHALL NOT start RUN.
REQ-024 step_cnt SHALL increment by 1 on every cpu_en pulse, wrapping 0xFFFFFFFF -> 0.
REQ-025 div_cnt SHALL wrap at 2^32 without side effects.

Reset
REQ-026 rst SHALL force state HALT, cpu_en=0, halted=1, bp_hit=0, step_cnt=0, div_cnt=0, all synchronizer and edge flops to 0; rst dominates all other inputs.
REQ-027 Because edge flops clear, run_sw held high through reset SHALL produce a rising edge and enter RUN 3 edges after rst deasserts.
REQ-028 rst asserted mid-RUN or mid-STEP SHALL abort with no further cpu_en pulse.

Configuration
REQ-029 Macro BRKPT_EN: when defined, a RUN tick with bp_valid=1 and pc==bp_addr SHALL be suppressed, state -> HALT, bp_hit<=1; bp_hit clears on leaving HALT; STEP ignores the breakpoint.
REQ-030 Without BRKPT_EN, pc/bp_addr/bp_valid SHALL remain ports but be unused, and bp_hit SHALL be constant 0.

Verification (FAST_LOG2=1, SLOW_LOG2=4)
REQ-031 rst 2 cycles, run_sw=0, step_btn=0 -> halted=1, cpu_en=0, step_cnt=0 for 50 cycles.
REQ-032 Pulse step_btn high 5 cycles at edge 10 -> single cpu_en after edge 12, step_cnt=1, halted=1 again.
REQ-033 run_sw rises, mode_slow=0 -> cpu_en every 2 cycles; switch mode_slow=1 -> every 16 cycles; after 40 pulses step_cnt=40.
REQ-034 run_sw drops on the same cycle a tick would fire -> no cpu_en, halted=1 next cycle; simultaneous run/step edges in HALT -> RUN, no STEP pulse.
REQ-035 BRKPT_EN, bp_valid=1, bp_addr=0x10, pc=0x10 at a tick -> no cpu_en, halted=1, bp_hit=1; step -> one cpu_en, bp_hit=0.
REQ-036 rst mid-RUN with run_sw held high -> outputs at reset values, RUN re-entered 3 edges after release.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//
// Run / halt / single-step clock-enable controller for a simple CPU core.
// The CPU is clocked on clk and advances one instruction on each cycle that
// cpu_en is high.
//
// In RUN the controller issues one cpu_en pulse every 2^FAST_LOG2 cycles,
// or every 2^SLOW_LOG2 cycles while mode_slow is high. In HALT a rising edge
// on step_btn issues exactly one pulse. A rising edge on run_sw starts RUN,
// and run_sw low returns the controller to HALT.
//
// Optional feature (macro BRKPT_EN): a RUN tick with bp_valid high and
// pc == bp_addr is swallowed and the controller halts with bp_hit set.
// Without BRKPT_EN the pc / bp_addr / bp_valid ports are present but unused,
// and bp_hit is tied low.
//
// Parameters
//   FAST_LOG2  log2 of the RUN tick period when mode_slow = 0
//   SLOW_LOG2  log2 of the RUN tick period when mode_slow = 1
//              (FAST_LOG2 .. 31)
//
// Ports
//   clk        system clock, every flop uses its rising edge
//   rst        synchronous, active-high reset
//   run_sw     asynchronous run/halt switch level
//   step_btn   asynchronous, pre-debounced single-step button level
//   mode_slow  asynchronous slow/fast tick select
//   pc         current CPU PC (BRKPT_EN only)
//   bp_addr    breakpoint address (BRKPT_EN only)
//   bp_valid   breakpoint armed (BRKPT_EN only)
//   cpu_en     registered one-cycle CPU clock-enable pulse
//   halted     registered, high while in HALT
//   bp_hit     registered, high while halted by the breakpoint
//   step_cnt   number of cpu_en pulses issued, wraps at 2^32
//
// State table
//   state  | meaning
//   HALT   | CPU stopped; waits for a run_sw or step_btn rising edge
//   RUN    | free running; cpu_en on each divider terminal count
//   STEP   | one-cycle state; cpu_en is high for exactly this cycle
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int unsigned FAST_LOG2 = 1,
    parameter int unsigned SLOW_LOG2 = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        mode_slow,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    output logic        cpu_en,
    output logic        halted,
    output logic        bp_hit,
    output logic [31:0] step_cnt
);

    // The masks are built in 33 bits so that a shift by 32 cannot overflow.
    // This covers the full legal range up to 31.
    localparam logic [32:0] ONE_33    = 33'd1;
    localparam logic [31:0] FAST_MASK = 32'((ONE_33 << FAST_LOG2) - ONE_33);
    localparam logic [31:0] SLOW_MASK = 32'((ONE_33 << SLOW_LOG2) - ONE_33);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] div_cnt;

    // Two-flop synchronizers. run and step each have a third flop that holds
    // the previous synced value, which is used for rising-edge detection.
    logic run_s1, run_s2, run_s3;
    logic step_s1, step_s2, step_s3;
    logic mode_s1, mode_s2;

    logic        run_rise;
    logic        step_rise;
    logic [31:0] tick_mask;
    logic        tick;
    logic        bp_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            run_s3  <= 1'b0;
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_s3 <= 1'b0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            run_s1  <= run_sw;
            run_s2  <= run_s1;
            run_s3  <= run_s2;
            step_s1 <= step_btn;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
            mode_s1 <= mode_slow;
            mode_s2 <= mode_s1;
        end
    end

    assign run_rise  = run_s2 & ~run_s3;
    assign step_rise = step_s2 & ~step_s3;

    // The tick period follows the synced mode immediately. The divider is not
    // restarted, so the first tick after a switch lands at the next point where
    // the low N bits are all ones.
    assign tick_mask = mode_s2 ? SLOW_MASK : FAST_MASK;
    assign tick      = ((div_cnt & tick_mask) == tick_mask);

`ifdef BRKPT_EN
    assign bp_match = bp_valid && (pc == bp_addr);
`else
    logic unused_bp;
    assign bp_match  = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HALT;
            cpu_en   <= 1'b0;
            halted   <= 1'b1;
            step_cnt <= 32'd0;
            div_cnt  <= 32'd0;
`ifdef BRKPT_EN
            bp_hit   <= 1'b0;
`endif
        end else begin
            cpu_en <= 1'b0;
            case (state)
                S_HALT: begin
                    // Run wins over a simultaneous step edge. The step edge is
                    // consumed here and never seen again.
                    if (run_rise) begin
                        state   <= S_RUN;
                        halted  <= 1'b0;
                        div_cnt <= 32'd0;
`ifdef BRKPT_EN
                        bp_hit  <= 1'b0;
`endif
                    end else if (step_rise) begin
                        state    <= S_STEP;
                        halted   <= 1'b0;
                        cpu_en   <= 1'b1;
                        step_cnt <= step_cnt + 32'd1;
`ifdef BRKPT_EN
                        bp_hit   <= 1'b0;
`endif
                    end
                end

                S_STEP: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end

                S_RUN: begin
                    if (!run_s2) begin
                        // Halting takes precedence over a tick in this cycle.
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (tick && bp_match) begin
                        // The instruction at the breakpoint is not executed.
                        state  <= S_HALT;
                        halted <= 1'b1;
`ifdef BRKPT_EN
                        bp_hit <= 1'b1;
`endif
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                        if (tick) begin
                            cpu_en   <= 1'b1;
                            step_cnt <= step_cnt + 32'd1;
                        end
                    end
                end

                default: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic        mode_slow;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [31:0] step_cnt;

    cpu_clk_ctrl #(.FAST_LOG2(1), .SLOW_LOG2(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .mode_slow (mode_slow),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    // cyc is the number of rising edges seen so far. Inputs are driven and
    // outputs are sampled on the falling edge that follows edge cyc.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [31:0] cnt;
    } pulse_t;

    typedef struct packed {
        int          cyc;
        logic        halted;
        logic        bp_hit;
        logic [31:0] cnt;
    } stat_t;

    pulse_t pq[$];
    stat_t  sq[$];
    int     n_vec  = 0;
    int     n_miss = 0;

    task automatic exp_pulse(input int c, input logic [31:0] cnt);
        pulse_t p;
        p.cyc = c;
        p.cnt = cnt;
        pq.push_back(p);
    endtask

    task automatic exp_stat(input int c, input logic h, input logic b, input logic [31:0] cnt);
        stat_t s;
        s.cyc    = c;
        s.halted = h;
        s.bp_hit = b;
        s.cnt    = cnt;
        sq.push_back(s);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: each cpu_en pulse must match the head of the pulse queue.
    // Status snapshots are compared at their scheduled cycle.
    always @(negedge clk) begin
        pulse_t p;
        stat_t  s;
        if (cpu_en) begin
            n_vec++;
            if (pq.size() != 0 && pq[0].cyc == cyc) begin
                p = pq.pop_front();
                if (step_cnt != p.cnt) begin
                    n_miss++;
                    $display("FAIL pulse_cnt: cycle %0d step_cnt got %0d expected %0d", cyc, step_cnt, p.cnt);
                end
            end else begin
                n_miss++;
                $display("FAIL pulse_unexpected: cpu_en=1 at cycle %0d, next expected pulse at %0d",
                         cyc, (pq.size() != 0) ? pq[0].cyc : -1);
            end
        end
        while (pq.size() != 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL pulse_missing: cpu_en=0 at cycle %0d, expected 1", p.cyc);
        end
        while (sq.size() != 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            n_vec++;
            if (s.cyc != cyc || halted !== s.halted || bp_hit !== s.bp_hit || step_cnt !== s.cnt) begin
                n_miss++;
                $display("FAIL status@%0d: got halted=%b bp_hit=%b step_cnt=%0d expected halted=%b bp_hit=%b step_cnt=%0d",
                         s.cyc, halted, bp_hit, step_cnt, s.halted, s.bp_hit, s.cnt);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        run_sw    = 1'b0;
        step_btn  = 1'b0;
        mode_slow = 1'b0;
        pc        = 32'h0;
        bp_addr   = 32'h0;
        bp_valid  = 1'b0;
        @(negedge clk);

        // Reset for edges 1 and 2, then sit idle.
        exp_stat(3, 1'b1, 1'b0, 32'd0);
        exp_stat(25, 1'b1, 1'b0, 32'd0);
        exp_stat(52, 1'b1, 1'b0, 32'd0);
        at(2);
        rst = 1'b0;

        // Single step: sampled high at edge 55, so the pulse follows edge 57.
        at(54);
        exp_stat(56, 1'b1, 1'b0, 32'd0);
        exp_pulse(57, 32'd1);
        exp_stat(57, 1'b0, 1'b0, 32'd1);
        exp_stat(58, 1'b1, 1'b0, 32'd1);
        exp_stat(70, 1'b1, 1'b0, 32'd1);
        step_btn = 1'b1;
        at(59);
        step_btn = 1'b0;

        // Run fast: RUN is entered at edge 83, with pulses on odd edges from 85.
        // Going slow at cycle 140 takes effect from edge 143, and the slow
        // ticks fall on edges 147 + 16m.
        at(80);
        for (int k = 0; k <= 28; k++) exp_pulse(85 + 2 * k, 32'(2 + k));
        for (int m = 0; m <= 9; m++) exp_pulse(147 + 16 * m, 32'(31 + m));
        exp_stat(84, 1'b0, 1'b0, 32'd1);
        exp_stat(292, 1'b0, 1'b0, 32'd40);
        run_sw = 1'b1;
        at(100);
        step_btn = 1'b1;              // ignored while running
        at(103);
        step_btn = 1'b0;
        at(140);
        mode_slow = 1'b1;

        // The synced run_sw goes low exactly as the edge-307 tick is due.
        at(304);
        exp_stat(306, 1'b0, 1'b0, 32'd40);
        exp_stat(307, 1'b1, 1'b0, 32'd40);
        exp_stat(320, 1'b1, 1'b0, 32'd40);
        run_sw = 1'b0;

        // Simultaneous run and step edges: RUN at edge 333, no STEP pulse.
        at(330);
        exp_pulse(335, 32'd41);
        exp_pulse(337, 32'd42);
        exp_stat(334, 1'b0, 1'b0, 32'd40);
        mode_slow = 1'b0;
        run_sw    = 1'b1;
        step_btn  = 1'b1;
        at(335);
        step_btn = 1'b0;

        // Reset mid-RUN with run_sw held high; RUN is re-entered at edge 343.
        at(338);
        exp_stat(339, 1'b1, 1'b0, 32'd0);
        exp_stat(342, 1'b1, 1'b0, 32'd0);
        exp_stat(343, 1'b0, 1'b0, 32'd0);
        exp_pulse(345, 32'd1);
        exp_pulse(347, 32'd2);
        exp_stat(348, 1'b1, 1'b0, 32'd2);
        rst = 1'b1;
        at(340);
        rst = 1'b0;
        at(345);
        run_sw = 1'b0;

        // Breakpoint address matches; RUN is entered at edge 363 and the first
        // tick is due at edge 365.
        at(360);
        pc       = 32'h10;
        bp_addr  = 32'h10;
        bp_valid = 1'b1;
`ifdef BRKPT_EN
        exp_stat(364, 1'b0, 1'b0, 32'd2);
        exp_stat(365, 1'b1, 1'b1, 32'd2);
        exp_stat(372, 1'b1, 1'b1, 32'd2);   // run_sw level alone does not restart
        exp_pulse(378, 32'd3);
        exp_stat(378, 1'b0, 1'b0, 32'd3);
        exp_stat(379, 1'b1, 1'b0, 32'd3);
        run_sw = 1'b1;
        at(375);
        step_btn = 1'b1;
        at(377);
        step_btn = 1'b0;
        at(380);
        run_sw = 1'b0;
`else
        exp_pulse(365, 32'd3);
        exp_stat(366, 1'b0, 1'b0, 32'd3);
        exp_pulse(367, 32'd4);
        exp_stat(368, 1'b1, 1'b0, 32'd4);
        run_sw = 1'b1;
        at(365);
        run_sw = 1'b0;
`endif

        at(400);
        @(negedge clk);
        while (pq.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL pulse_missing: expected pulse at cycle %0d never seen", pq[0].cyc);
            void'(pq.pop_front());
        end
        while (sq.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL status_missing: snapshot at cycle %0d never taken", sq[0].cyc);
            void'(sq.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
